// File: rtl/mdu_ctrl_pkg.sv
// Shared MDUOp encodings, default operation latencies and the controller state type.
package mdu_ctrl_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath: A op B -> {hi, lo}, dz flags a zero divisor.
// Reserved MDUOp codes 4..7 fall through to signed multiply.
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dz
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic        b_zero;
  logic [31:0] a_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide runs on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
  assign a_neg   = (MDUOp == MDU_DIV) & A[31];
  assign b_neg   = (MDUOp == MDU_DIV) & B[31];
  assign b_zero  = (B == 32'd0);
  assign a_mag   = a_neg ? (32'd0 - A) : A;
  assign divisor = b_zero ? 32'd1 : (b_neg ? (32'd0 - B) : B);
  assign q_mag   = a_mag / divisor;
  assign r_mag   = a_mag % divisor;

  always_comb begin
    dz = 1'b0;
    hi = prod_s[63:32];
    lo = prod_s[31:0];
    case (MDUOp)
      MDU_MULTU: begin
        hi = prod_u[63:32];
        lo = prod_u[31:0];
      end
      MDU_DIV, MDU_DIVU: begin
        dz = b_zero;
        lo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        hi = a_neg ? (32'd0 - r_mag) : r_mag;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: fixed-latency sequencing, HI/LO ownership, D-stage stall.
// Optional MDU_CANCEL_EN makes the cancel input abort an in-flight operation.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | no op in flight; mthi/mtlo accepted; start latches pending
//   ST_BUSY | counting down; at cnt==1 the next edge commits pending HI/LO
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic        HIWr,
  input  logic        LOWr,
  input  logic        HILOSel,
  input  logic        isMD_D,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cancel,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  mdu_state_e  state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_dz;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        calc_dz;
  logic        cancel_req;

`ifdef MDU_CANCEL_EN
  assign cancel_req = cancel;
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_req    = 1'b0;
`endif

  mdu_calc u_calc (
    .A     (A),
    .B     (B),
    .MDUOp (MDUOp),
    .hi    (calc_hi),
    .lo    (calc_lo),
    .dz    (calc_dz)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      busy    <= 1'b0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_dz <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pend_hi <= calc_hi;
            pend_lo <= calc_lo;
            pend_dz <= calc_dz;
            cnt     <= is_div(MDUOp) ? DIV_LAT : MULT_LAT;
            busy    <= 1'b1;
            state   <= ST_BUSY;
          end else begin
            if (HIWr) HI <= A;
            if (LOWr) LO <= A;
          end
        end
        ST_BUSY: begin
          if (cancel_req) begin
            cnt   <= 4'd0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (cnt == 4'd1) begin
            // A zero divisor burns the full latency but leaves HI/LO alone.
            if (!pend_dz) begin
              HI <= pend_hi;
              LO <= pend_lo;
            end
            cnt   <= 4'd0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

  assign stall = isMD_D & (start | busy);
  assign MDOut = HILOSel ? HI : LO;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: arithmetic model plus directed scenarios with literal expectations.
module tb_mdu_ctrl;

  localparam int LAT_MULT = 5;
  localparam int LAT_DIV  = 10;
`ifdef MDU_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  MDUOp = 3'd0;
  logic        HIWr = 1'b0;
  logic        LOWr = 1'b0;
  logic        HILOSel = 1'b0;
  logic        isMD_D = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDOut;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  mdu_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .MDUOp   (MDUOp),
    .HIWr    (HIWr),
    .LOWr    (LOWr),
    .HILOSel (HILOSel),
    .isMD_D  (isMD_D),
    .A       (A),
    .B       (B),
    .cancel  (cancel),
    .busy    (busy),
    .stall   (stall),
    .HI      (HI),
    .LO      (LO),
    .MDOut   (MDOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the ISA rules, using 64-bit integer math.
  function automatic logic [64:0] model_calc(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        return {1'b0, p};
      end
      3'd2: begin
        if (b == 32'd0) return {1'b1, 64'd0};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {1'b1, 64'd0};
        return {1'b0, a % b, a / b};
      end
      default: begin
        p = sa * sb;
        return {1'b0, p};
      end
    endcase
  endfunction

  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  logic        p_dz = 1'b0;
  int          m_left = 0;
  logic        exp_busy;

  always @(posedge clk) begin
    if (checking && !reset)
      chk("start while busy", {31'd0, start & (m_left > 0)}, 32'd0);
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
    end else if (m_left > 0) begin
      if (CANCEL_EN && cancel) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0 && !p_dz) begin
          m_hi = p_hi; m_lo = p_lo;
        end
      end
    end else if (start) begin
      {p_dz, p_hi, p_lo} = model_calc(MDUOp, A, B);
      m_left = (MDUOp == 3'd2 || MDUOp == 3'd3) ? LAT_DIV : LAT_MULT;
    end else begin
      if (HIWr) m_hi = A;
      if (LOWr) m_lo = A;
    end
    #1;
    if (checking) begin
      exp_busy = (m_left > 0);
      chk("model busy",  {31'd0, busy},  {31'd0, exp_busy});
      chk("model stall", {31'd0, stall}, {31'd0, isMD_D & (start | exp_busy)});
      chk("model HI",    HI,    m_hi);
      chk("model LO",    LO,    m_lo);
      chk("model MDOut", MDOut, HILOSel ? m_hi : m_lo);
    end
  end

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] ehi,
                        input logic [31:0] elo);
    int n;
    @(negedge clk);
    start = 1'b1; MDUOp = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    wait_idle(n);
    chk({name, " latency"}, n, lat);
    chk({name, " HI"}, HI, ehi);
    chk({name, " LO"}, LO, elo);
  endtask

  task automatic write_hilo(input logic hw, input logic lw, input logic [31:0] d);
    @(negedge clk);
    HIWr = hw; LOWr = lw; A = d;
    @(negedge clk);
    HIWr = 1'b0; LOWr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("reset busy",  {31'd0, busy},  32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    reset = 1'b0;
    checking = 1'b1;

    run_op("mult -3*4", 3'd0, 32'hFFFF_FFFD, 32'd4, LAT_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
    run_op("div -7/2",  3'd2, 32'hFFFF_FFF9, 32'd2, LAT_DIV,  32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 7/2",  3'd3, 32'd7,         32'd2, LAT_DIV,  32'd1,         32'd3);

    // mfhi sitting in D while multu runs: stall covers start cycle plus every busy cycle.
    @(negedge clk);
    start = 1'b1; MDUOp = 3'd1; A = 32'hFFFF_FFFF; B = 32'd2; isMD_D = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (stall) n++;
      @(negedge clk);
      start = 1'b0;
    end
    chk("multu stall cycles", n, 32'd6);
    isMD_D = 1'b0;
    HILOSel = 1'b1;
    #1 chk("mfhi after multu", MDOut, 32'h0000_0001);
    HILOSel = 1'b0;
    #1 chk("mflo after multu", MDOut, 32'hFFFF_FFFE);

    write_hilo(1'b1, 1'b0, 32'h1234_5678);
    chk("mthi HI", HI, 32'h1234_5678);
    chk("mthi LO kept", LO, 32'hFFFF_FFFE);
    HILOSel = 1'b1;
    #1 chk("mfhi after mthi", MDOut, 32'h1234_5678);

    // mthi during busy is dropped.
    @(negedge clk);
    start = 1'b1; MDUOp = 3'd0; A = 32'd3; B = 32'd3;
    @(negedge clk);
    start = 1'b0; HIWr = 1'b1; A = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    HIWr = 1'b0;
    wait_idle(n);
    chk("mthi while busy HI", HI, 32'd0);
    chk("mthi while busy LO", LO, 32'd9);

    // start and mthi together: start wins.
    @(negedge clk);
    start = 1'b1; HIWr = 1'b1; MDUOp = 3'd0; A = 32'd2; B = 32'd5;
    @(negedge clk);
    start = 1'b0; HIWr = 1'b0;
    wait_idle(n);
    chk("start+mthi HI", HI, 32'd0);
    chk("start+mthi LO", LO, 32'd10);

    write_hilo(1'b1, 1'b1, 32'h0000_00AA);
    chk("mthi+mtlo HI", HI, 32'h0000_00AA);
    chk("mthi+mtlo LO", LO, 32'h0000_00AA);
    write_hilo(1'b0, 1'b1, 32'h0000_00BB);
    run_op("divu by 0", 3'd3, 32'd77, 32'd0, LAT_DIV, 32'h0000_00AA, 32'h0000_00BB);
    run_op("div by 0",  3'd2, 32'd77, 32'd0, LAT_DIV, 32'h0000_00AA, 32'h0000_00BB);
    run_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, LAT_DIV, 32'd0, 32'h8000_0000);
    run_op("op5 as mult", 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_MULT, 32'd0, 32'd1);
    run_op("multu big", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_MULT, 32'hFFFF_FFFE, 32'd1);

    // Reset in busy cycle 3 discards the op and clears HI/LO at once.
    write_hilo(1'b1, 1'b1, 32'h0000_0055);
    @(negedge clk);
    start = 1'b1; MDUOp = 3'd0; A = 32'd7; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy before reset", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid reset busy", {31'd0, busy}, 32'd0);
    chk("mid reset HI", HI, 32'd0);
    chk("mid reset LO", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // cancel asserted in busy cycle 2.
    write_hilo(1'b1, 1'b0, 32'h0000_0011);
    write_hilo(1'b0, 1'b1, 32'h0000_0022);
    @(negedge clk);
    start = 1'b1; MDUOp = 3'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    if (CANCEL_EN) begin
      chk("cancel busy", {31'd0, busy}, 32'd0);
      repeat (12) @(negedge clk);
      chk("cancel HI", HI, 32'h0000_0011);
      chk("cancel LO", LO, 32'h0000_0022);
    end else begin
      chk("cancel ignored busy", {31'd0, busy}, 32'd1);
      wait_idle(n);
      chk("cancel ignored HI", HI, 32'd2);
      chk("cancel ignored LO", LO, 32'd14);
    end

    repeat (3) @(negedge clk);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
